// File: rtl/discharge_pkg.sv
// Shared encodings and constants for the discharge pulse scheduler.
package discharge_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_OFF  = 2'd3;

    localparam logic [15:0] SHORT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/discharge_tick_gen.sv
// Time-base divider: tick every TICK_DIV clocks, held at phase 0 while hold is set.
import discharge_pkg::*;

module discharge_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_r;

    assign tick = (div_r == DIV_LAST);

    // divider phase register, cleared while held so the first ON tick aligns to LOAD exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= '0;
        end else if (hold || tick) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/discharge_pulse_scheduler.sv
// Discharge on/off pulse sequencer with boundary-captured parameters and statistics.
// Optional gap short-circuit abort is enabled by defining DISCHARGE_SHORT_PROTECT_EN.
module discharge_pulse_scheduler
    import discharge_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int TICK_DIV = 1,
    parameter int PCNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_machine,
    input  logic [CNT_W-1:0]  Ton_data,
    input  logic [CNT_W-1:0]  Toff_data,
    input  logic [15:0]       Ip_data,
    input  logic [15:0]       waveform_data,
    input  logic              short_detect,
    output logic              pulse_on,
    output logic [15:0]       Ip_set,
    output logic [15:0]       waveform_sel,
    output logic              pulse_done,
    output logic [PCNT_W-1:0] pulse_cnt,
    output logic [15:0]       short_cnt,
    output logic [1:0]        state
);

    logic [1:0]        state_r;
    logic [1:0]        next_state_s;
    logic [CNT_W-1:0]  phase_r;
    logic [CNT_W-1:0]  phase_d_s;
    logic [CNT_W-1:0]  toff_r;
    logic [15:0]       ip_r;
    logic [15:0]       wave_r;
    logic [15:0]       short_cnt_r;
    logic [PCNT_W-1:0] pulse_cnt_r;
    logic              pulse_on_r;
    logic              pulse_on_d_s;
    logic              tick_s;
    logic              hold_s;
    logic              on_expire_s;
    logic              off_expire_s;
    logic              short_abort_s;

    function automatic logic [CNT_W-1:0] min_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    assign hold_s = (state_r == ST_IDLE) || (state_r == ST_LOAD);

    discharge_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .hold (hold_s),
        .tick (tick_s)
    );

    assign on_expire_s  = (state_r == ST_ON)  && tick_s && (phase_r == CNT_W'(1));
    assign off_expire_s = (state_r == ST_OFF) && tick_s && (phase_r == CNT_W'(1));

`ifdef DISCHARGE_SHORT_PROTECT_EN
    assign short_abort_s = (state_r == ST_ON) && short_detect;
`else
    logic unused_short_s;
    assign unused_short_s = short_detect;
    assign short_abort_s  = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (is_machine) next_state_s = ST_LOAD;
                else            next_state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (Ton_data == '0) next_state_s = ST_OFF;
                else                next_state_s = ST_ON;
            end
            ST_ON: begin
                if (short_abort_s || on_expire_s) next_state_s = ST_OFF;
                else                              next_state_s = ST_ON;
            end
            ST_OFF: begin
                if (off_expire_s && is_machine) next_state_s = ST_LOAD;
                else if (off_expire_s)          next_state_s = ST_IDLE;
                else                            next_state_s = ST_OFF;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: gate drive and phase counter next values
    always_comb begin
        pulse_on_d_s = (next_state_s == ST_ON);
        phase_d_s    = phase_r;
        case (state_r)
            ST_IDLE: phase_d_s = '0;
            ST_LOAD: begin
                if (Ton_data == '0) phase_d_s = min_one(Toff_data);
                else                phase_d_s = Ton_data;
            end
            ST_ON: begin
                if (next_state_s == ST_OFF) phase_d_s = min_one(toff_r);
                else if (tick_s)            phase_d_s = phase_r - CNT_W'(1);
                else                        phase_d_s = phase_r;
            end
            ST_OFF: begin
                if (tick_s) phase_d_s = phase_r - CNT_W'(1);
                else        phase_d_s = phase_r;
            end
            default: phase_d_s = '0;
        endcase
    end

    // datapath: shadow parameters, phase counter, gate drive and statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_on_r  <= 1'b0;
            phase_r     <= '0;
            toff_r      <= '0;
            ip_r        <= 16'd0;
            wave_r      <= 16'd0;
            pulse_cnt_r <= '0;
            short_cnt_r <= 16'd0;
        end else begin
            pulse_on_r <= pulse_on_d_s;
            phase_r    <= phase_d_s;
            if (state_r == ST_LOAD) begin
                toff_r <= Toff_data;
                ip_r   <= Ip_data;
                wave_r <= waveform_data;
            end
            if (off_expire_s) begin
                pulse_cnt_r <= pulse_cnt_r + PCNT_W'(1);
            end
            // an abort coinciding with ON expiry still counts as a short
            if (short_abort_s && (short_cnt_r != SHORT_CNT_MAX)) begin
                short_cnt_r <= short_cnt_r + 16'd1;
            end
        end
    end

    assign pulse_on     = pulse_on_r;
    assign Ip_set       = ip_r;
    assign waveform_sel = wave_r;
    assign pulse_done   = off_expire_s;
    assign pulse_cnt    = pulse_cnt_r;
    assign short_cnt    = short_cnt_r;
    assign state        = state_r;

endmodule

// File: tb/tb_discharge_pulse_scheduler.sv
// Scoreboard bench for discharge_pulse_scheduler: unit A at TICK_DIV=1, unit B at TICK_DIV=4.
module tb_discharge_pulse_scheduler;
    import discharge_pkg::*;

`ifdef DISCHARGE_SHORT_PROTECT_EN
    localparam int T5_ON = 3;
    localparam int T5_SH = 1;
`else
    localparam int T5_ON = 8;
    localparam int T5_SH = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_is_machine, a_short;
    logic [15:0] a_ton, a_toff, a_ip, a_wave;
    logic        a_pulse_on, a_pulse_done;
    logic [15:0] a_ip_set, a_wave_sel, a_short_cnt;
    logic [31:0] a_pulse_cnt;
    logic [1:0]  a_state;

    logic        b_rst, b_is_machine, b_short;
    logic [15:0] b_ton, b_toff, b_ip, b_wave;
    logic        b_pulse_on, b_pulse_done;
    logic [15:0] b_ip_set, b_wave_sel, b_short_cnt;
    logic [31:0] b_pulse_cnt;
    logic [1:0]  b_state;

    discharge_pulse_scheduler #(.CNT_W(16), .TICK_DIV(1), .PCNT_W(32)) u_dut_a (
        .clk(clk), .rst(a_rst), .is_machine(a_is_machine),
        .Ton_data(a_ton), .Toff_data(a_toff), .Ip_data(a_ip), .waveform_data(a_wave),
        .short_detect(a_short), .pulse_on(a_pulse_on), .Ip_set(a_ip_set),
        .waveform_sel(a_wave_sel), .pulse_done(a_pulse_done), .pulse_cnt(a_pulse_cnt),
        .short_cnt(a_short_cnt), .state(a_state)
    );

    discharge_pulse_scheduler #(.CNT_W(16), .TICK_DIV(4), .PCNT_W(32)) u_dut_b (
        .clk(clk), .rst(b_rst), .is_machine(b_is_machine),
        .Ton_data(b_ton), .Toff_data(b_toff), .Ip_data(b_ip), .waveform_data(b_wave),
        .short_detect(b_short), .pulse_on(b_pulse_on), .Ip_set(b_ip_set),
        .waveform_sel(b_wave_sel), .pulse_done(b_pulse_done), .pulse_cnt(b_pulse_cnt),
        .short_cnt(b_short_cnt), .state(b_state)
    );

    typedef struct {
        int          on_len;
        int          off_len;
        int          gap;
        int          cnt;
        int          shorts;
        logic [15:0] ip;
        logic [15:0] wave;
    } exp_t;

    exp_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int on_len, input int off_len, input int gap, input int cnt,
                            input int shorts, input logic [15:0] ip, input logic [15:0] wave);
        exp_t e;
        e.on_len = on_len; e.off_len = off_len; e.gap = gap; e.cnt = cnt;
        e.shorts = shorts; e.ip = ip; e.wave = wave;
        exp_q.push_back(e);
    endtask

    // Monitor: measures each completed pulse of unit A and compares against the queue
    int on_len = 0, off_len = 0, cyc = 0, last_done = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!a_rst) begin
            cyc++;
            if (a_pulse_on) on_len++;
            if (a_state == ST_OFF) off_len++;
            if (a_pulse_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("on_len", on_len, e.on_len);
                    check("off_len", off_len, e.off_len);
                    if (e.gap > 0) check("period", cyc - last_done, e.gap);
                    check("pulse_cnt_at_done", a_pulse_cnt, e.cnt);
                    check("short_cnt_at_done", a_short_cnt, e.shorts);
                    check("ip_set", a_ip_set, e.ip);
                    check("waveform_sel", a_wave_sel, e.wave);
                end
                last_done = cyc;
                on_len    = 0;
                off_len   = 0;
            end
        end
    end

    task automatic wait_done_a(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_pulse_done && n < 300);
        if (!a_pulse_done) check(name, a_pulse_done, 1);
    endtask

    task automatic wait_on_a(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_pulse_on && n < 300);
        if (!a_pulse_on) check(name, a_pulse_on, 1);
    endtask

    initial begin
        int n;
        int bad;
        a_rst = 1'b1; a_is_machine = 1'b0; a_short = 1'b0;
        a_ton = 16'd0; a_toff = 16'd0; a_ip = 16'd0; a_wave = 16'd0;
        b_rst = 1'b1; b_is_machine = 1'b0; b_short = 1'b0;
        b_ton = 16'd0; b_toff = 16'd0; b_ip = 16'd0; b_wave = 16'd0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_pulse_on", a_pulse_on, 0);
        check("rst_state", a_state, 0);
        check("rst_pulse_cnt", a_pulse_cnt, 0);
        check("rst_short_cnt", a_short_cnt, 0);
        check("rst_ip_set", a_ip_set, 0);
        check("rst_pulse_done", a_pulse_done, 0);
        a_rst = 1'b0;
        @(negedge clk);

        // test 1: Ton=5 Toff=3 continuous, latency and period 9
        a_ton = 16'd5; a_toff = 16'd3; a_ip = 16'h0123; a_wave = 16'h0001; a_is_machine = 1'b1;
        push_exp(5, 3, 0, 0, 0, 16'h0123, 16'h0001);
        push_exp(5, 3, 9, 1, 0, 16'h0123, 16'h0001);
        push_exp(5, 3, 9, 2, 0, 16'h0123, 16'h0001);
        @(negedge clk);
        check("latency_load_state", a_state, 1);
        check("latency_load_pulse_on", a_pulse_on, 0);
        @(negedge clk);
        check("latency_on_pulse_on", a_pulse_on, 1);
        check("latency_on_state", a_state, 2);
        wait_done_a("t1_done0");
        wait_done_a("t1_done1");
        wait_done_a("t1_done2");

        // test 2: Ton=0 Toff=0 -> done every 2 cycles, never on
        a_ton = 16'd0; a_toff = 16'd0; a_ip = 16'h0456; a_wave = 16'h0002;
        push_exp(0, 1, 2, 3, 0, 16'h0456, 16'h0002);
        push_exp(0, 1, 2, 4, 0, 16'h0456, 16'h0002);
        push_exp(0, 1, 2, 5, 0, 16'h0456, 16'h0002);
        wait_done_a("t2_done0");
        wait_done_a("t2_done1");
        wait_done_a("t2_done2");

        // test 3: Ton change mid-ON takes effect only on the next pulse
        a_ton = 16'd5; a_toff = 16'd3; a_ip = 16'h0789; a_wave = 16'h0003;
        push_exp(5, 3, 9, 6, 0, 16'h0789, 16'h0003);
        wait_on_a("t3_on0");
        repeat (2) @(negedge clk);
        a_ton = 16'd10; a_ip = 16'h0ABC; a_wave = 16'h0004;
        push_exp(10, 3, 14, 7, 0, 16'h0ABC, 16'h0004);
        wait_done_a("t3_done0");
        wait_on_a("t3_on1");
        repeat (2) @(negedge clk);
        a_ton = 16'd5; a_ip = 16'h0DEF; a_wave = 16'h0005;
        push_exp(5, 3, 9, 8, 0, 16'h0DEF, 16'h0005);
        wait_done_a("t3_done1");

        // test 4: stop 2 cycles into ON -> full pulse then IDLE
        wait_on_a("t4_on");
        repeat (2) @(negedge clk);
        a_is_machine = 1'b0;
        wait_done_a("t4_done");
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (a_pulse_on || a_state != ST_IDLE) bad++;
        end
        check("t4_idle_after_stop", bad, 0);

        // test 5: short during ON cycle 2 of Ton=8
        a_ton = 16'd8; a_toff = 16'd3; a_ip = 16'h1111; a_wave = 16'h0006; a_is_machine = 1'b1;
        push_exp(T5_ON, 3, 0, 9, T5_SH, 16'h1111, 16'h0006);
        wait_on_a("t5_on");
        repeat (2) @(negedge clk);
        a_short = 1'b1; a_is_machine = 1'b0;
        @(negedge clk);
        a_short = 1'b0;
        wait_done_a("t5_done");
        repeat (3) @(negedge clk);
        check("t5_state_idle", a_state, 0);
        check("final_pulse_cnt", a_pulse_cnt, 10);
        check("final_short_cnt", a_short_cnt, T5_SH);
        check("queue_drained", exp_q.size(), 0);

        // test 6: TICK_DIV=4, reset mid-ON, restart latency and length
        b_ton = 16'd2; b_toff = 16'd1; b_ip = 16'h0ABC; b_wave = 16'h0007; b_is_machine = 1'b1;
        b_rst = 1'b0;
        n = 0;
        while (!b_pulse_on && n < 50) begin @(negedge clk); n++; end
        check("b_latency", n, 2);
        n = 0;
        while (b_pulse_on && n < 100) begin n++; @(negedge clk); end
        check("b_on_len", n, 8);
        n = 1;
        while (!b_pulse_done && n < 100) begin @(negedge clk); n++; end
        check("b_off_len", n, 4);
        @(negedge clk);
        check("b_pulse_cnt", b_pulse_cnt, 1);
        n = 0;
        while (!b_pulse_on && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        b_rst = 1'b1;
        #1;
        check("b_rst_pulse_on", b_pulse_on, 0);
        check("b_rst_state", b_state, 0);
        check("b_rst_pulse_cnt", b_pulse_cnt, 0);
        check("b_rst_short_cnt", b_short_cnt, 0);
        check("b_rst_ip_set", b_ip_set, 0);
        @(negedge clk);
        b_rst = 1'b0;
        n = 0;
        while (!b_pulse_on && n < 50) begin @(negedge clk); n++; end
        check("b_restart_latency", n, 2);
        n = 0;
        while (b_pulse_on && n < 100) begin n++; @(negedge clk); end
        check("b_restart_on_len", n, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
